// File: rtl/bit_field_pkg.sv
// bit_field_pkg: shared FSM states, default widths and width clamp for bit-field insert/select
package bit_field_pkg;
   localparam int WORD_W_DEF  = 32;
   localparam int FIELD_W_DEF = 16;
   localparam int OFS_W_DEF   = 5;
   typedef enum logic [1:0] {IDLE, MASK, MERGE, HOLD} state_t;
   function automatic logic [4:0] clamp_width(input logic [4:0] w, input int max_w);
      return (int'(w) > max_w) ? 5'(max_w) : w;
   endfunction
endpackage

// File: rtl/bit_field_mask_gen.sv
// bit_field_mask_gen: field mask at (lsb, width) plus flag for a field running past the word top
module bit_field_mask_gen #(
   parameter int WORD_W = 32,
   parameter int OFS_W  = 5
) (
   input  logic [OFS_W-1:0]  lsb_i,
   input  logic [4:0]        width_i,
   output logic [WORD_W-1:0] mask_o,
   output logic              clip_o
);
   localparam logic [2*WORD_W-1:0] ONE = {{(2*WORD_W-1){1'b0}}, 1'b1};
   // double-width shift so bits past the top are dropped rather than wrapped
   assign mask_o = WORD_W'(((ONE << width_i) - ONE) << lsb_i);
   assign clip_o = ((OFS_W+1)'(lsb_i) + (OFS_W+1)'(width_i)) > (OFS_W+1)'(WORD_W);
endmodule

// File: rtl/bit_field_insert.sv
// bit_field_insert: merges the low width bits of field into base at bit lsb, valid/ready on both sides
module bit_field_insert
   import bit_field_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int FIELD_W = FIELD_W_DEF,
   parameter int OFS_W   = OFS_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_base,
   input  logic [FIELD_W-1:0] in_field,
   input  logic [OFS_W-1:0]   in_lsb,
   input  logic [4:0]         in_width,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORD_W-1:0]  out_word,
   output logic               out_clipped
);
   state_t             state_q;
   logic [WORD_W-1:0]  base_q, mask_q, shifted_q, word_q;
   logic [WORD_W-1:0]  mask_d, shifted_d, word_d;
   logic [FIELD_W-1:0] field_q;
   logic [OFS_W-1:0]   lsb_q;
   logic [4:0]         w_q;
   logic               clip_q, clip_d, clipped_q, in_ready_q, out_valid_q;

   bit_field_mask_gen #(.WORD_W(WORD_W), .OFS_W(OFS_W)) u_mask (
      .lsb_i  (lsb_q),
      .width_i(w_q),
      .mask_o (mask_d),
      .clip_o (clip_d)
   );

   // field bits above the width land outside the mask, so masking after the shift suffices
   assign shifted_d = WORD_W'((2*WORD_W)'(field_q) << lsb_q) & mask_d;
   assign word_d    = (base_q & ~mask_q) | (shifted_q & mask_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         base_q      <= '0;
         field_q     <= '0;
         lsb_q       <= '0;
         w_q         <= '0;
         mask_q      <= '0;
         shifted_q   <= '0;
         clip_q      <= 1'b0;
         word_q      <= '0;
         clipped_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               base_q     <= in_base;
               field_q    <= in_field;
               lsb_q      <= in_lsb;
               w_q        <= clamp_width(in_width, FIELD_W);
               in_ready_q <= 1'b0;
               state_q    <= MASK;
            end
            MASK: begin
               mask_q    <= mask_d;
               shifted_q <= shifted_d;
               clip_q    <= clip_d;
               state_q   <= MERGE;
            end
            MERGE: begin
               word_q      <= word_d;
               clipped_q   <= clip_q;
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_word    = word_q;
   assign out_clipped = clipped_q;
endmodule

// File: tb/tb_bit_field_insert.sv
// tb_bit_field_insert: directed and random requests checked every cycle against a bit-loop model
module tb_bit_field_insert;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_base = '0;
   logic [15:0] in_field = '0;
   logic [4:0]  in_lsb = '0;
   logic [4:0]  in_width = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_word;
   logic        out_clipped;

   bit_field_insert dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_base(in_base), .in_field(in_field), .in_lsb(in_lsb), .in_width(in_width),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_clipped(out_clipped)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] w; logic c; int acc; bit seen;} exp_t;
   exp_t        q[$];
   int          acc_log[$];
   int          checks = 0, errors = 0, cyc = 0;
   logic [31:0] last_w = '0;
   logic        last_c = 1'b0;
   bit          rnd_rdy = 1'b0;
   logic        rdy_val = 1'b1;
   logic [31:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   task automatic chk(input string n, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // bit-by-bit replacement: {clip, word}
   function automatic logic [32:0] model(input logic [31:0] b, input logic [15:0] f, input int l, input int w);
      int          wc = (w > 16) ? 16 : w;
      logic [31:0] r = b;
      for (int i = 0; i < 32; i++)
         if (i >= l && i < l + wc) r[i] = f[i-l];
      return {(l + wc > 32), r};
   endfunction

   always @(negedge clk) begin
      logic [32:0] m;
      if (reset) begin
         q.delete();
         last_w = '0;
         last_c = 1'b0;
      end else begin
         chk("in_ready", in_ready, q.size() == 0);
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_valid", out_valid, 0);
            else begin
               chk("word", out_word, q[0].w);
               chk("clipped", out_clipped, q[0].c);
               if (!q[0].seen) begin
                  chk("latency", cyc, q[0].acc + 3);
                  q[0].seen = 1'b1;
                  last_w = q[0].w;
                  last_c = q[0].c;
               end
               if (out_ready) void'(q.pop_front());
            end
         end else begin
            chk("hold_word", out_word, last_w);
            chk("hold_clip", out_clipped, last_c);
            if (q.size() != 0 && cyc >= q[0].acc + 3) chk("late_valid", out_valid, 1);
         end
         if (in_valid && in_ready) begin
            m = model(in_base, in_field, int'(in_lsb), int'(in_width));
            q.push_back('{w: m[31:0], c: m[32], acc: cyc, seen: 1'b0});
            acc_log.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [31:0] b, input logic [15:0] f, input logic [4:0] l, input logic [4:0] w);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_base  = b;
      in_field = f;
      in_lsb   = l;
      in_width = w;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) chk("accept_timeout", in_ready, 1);
   endtask

   task automatic drop();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string n, input logic [31:0] ew, input logic ec);
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      if (!ok) chk({n, "_timeout"}, out_valid, 1);
      chk({n, "_word"}, out_word, ew);
      chk({n, "_clip"}, out_clipped, ec);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_word", out_word, 0);
      chk("rst_out_clipped", out_clipped, 0);

      chk("model_basic", model(32'hFFFFFFFF, 16'hABCD, 4, 16), {1'b0, 32'hFFFABCDF});
      chk("model_clip", model(32'h0, 16'h1234, 24, 16), {1'b1, 32'h34000000});
      chk("model_noop", model(32'h12345678, 16'hFFFF, 7, 0), {1'b0, 32'h12345678});
      chk("model_clamp", model(32'h0, 16'hFFFF, 0, 31), {1'b0, 32'h0000FFFF});

      send(32'hFFFFFFFF, 16'hABCD, 5'd4, 5'd16);  drop(); wait_out("basic", 32'hFFFABCDF, 1'b0);
      send(32'h00000000, 16'h1234, 5'd24, 5'd16); drop(); wait_out("clip", 32'h34000000, 1'b1);
      send(32'h12345678, 16'hFFFF, 5'd7, 5'd0);   drop(); wait_out("noop", 32'h12345678, 1'b0);
      send(32'h00000000, 16'hFFFF, 5'd0, 5'd31);  drop(); wait_out("clamp", 32'h0000FFFF, 1'b0);
      drain();

      rdy_val = 1'b0;
      send(32'hA5A5A5A5, 16'h00FF, 5'd8, 5'd4); drop(); wait_out("bp", 32'hA5A5AFA5, 1'b0);
      held = out_word;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_stable", out_word, held);
      end
      rdy_val = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_accept_valid", out_valid, 1);
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_valid", out_valid, 0);

      send(32'hDEADBEEF, 16'h0001, 5'd0, 5'd8); drop();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_word", out_word, 0);
      repeat (8) @(negedge clk);

      acc_log.delete();
      send(32'h11111111, 16'hBEEF, 5'd0, 5'd16);
      send(32'h22222222, 16'h000F, 5'd28, 5'd8);
      send(32'h33333333, 16'h0000, 5'd12, 5'd3);
      drop();
      drain();
      chk("b2b_count", acc_log.size(), 3);
      if (acc_log.size() == 3) begin
         chk("b2b_gap1", acc_log[1] - acc_log[0], 4);
         chk("b2b_gap2", acc_log[2] - acc_log[1], 4);
      end

      rnd_rdy = 1'b1;
      for (int n = 0; n < 150; n++) begin
         send($urandom, 16'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         drop();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      rnd_rdy = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/bit_field_insert.md
Name: bit_field_insert

Overview:
- Write-side counterpart of bit-field selection: merges a narrow field into a 32-bit word at a runtime bit offset and width.
- Produces `base` with bits `[lsb +: width]` replaced by the low `width` bits of `field`. All other bits pass through unchanged.
- Sits between register-file read data and write-back in generated FSM datapaths. Uses valid/ready handshakes on both sides.

Parameters:
- WORD_W, 32, width of base word and result
- FIELD_W, 16, maximum field width in bits
- OFS_W, 5, width of lsb offset port; must equal clog2(WORD_W)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_base  input  WORD_W  word to be modified
- in_field  input  FIELD_W  field value (low bits used)
- in_lsb  input  OFS_W  bit position of field LSB within word
- in_width  input  5  field width in bits; 0 = no-op, values above FIELD_W clamp to FIELD_W
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_word  output  WORD_W  merged word
- out_clipped  output  1  field extended past bit WORD_W-1 and was truncated

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0
  - out_word = 0, out_clipped = 0
  - all internal registers = 0
- FSM states: IDLE, MASK, MERGE, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid, register base, field, lsb and clamped width; go to MASK.
- MASK:
  - Build mask = ((1 << w) - 1) << lsb, truncated to WORD_W. Width-0 mask is all zeros.
  - Build shifted = (field & ((1 << w) - 1)) << lsb, truncated to WORD_W.
  - clip = (lsb + w > WORD_W), computed 6 bits wide with no overflow.
  - Go to MERGE.
- MERGE:
  - Register out_word = (base & ~mask) | (shifted & mask).
  - Register out_clipped = clip.
  - Go to HOLD.
- HOLD:
  - out_valid = 1; out_word and out_clipped held stable.
  - On out_ready, go to IDLE; out_valid falls next cycle.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored; the producer must hold it.
- Latency: handshake at edge N → out_valid high from cycle N+3.
- Minimum spacing between accepts is 4 cycles when out_ready is held high.
- out_word retains its last value after HOLD until the next MERGE. out_clipped likewise.
- Shift arithmetic is done at 2*WORD_W internally and then truncated. There is no wrap-around: bits shifted past WORD_W-1 are discarded.
- Width clamp applies before mask generation; a clamped width does not set clipped.
- Reset asserted in any state returns to IDLE next edge and drops out_valid. An in-flight request is discarded without output.
- Reset and in_valid in the same cycle: reset wins; no capture.

Decomposition:
- Shared package bit_field_pkg holds:
  - state enum: IDLE, MASK, MERGE, HOLD
  - WORD_W / FIELD_W / OFS_W defaults
  - function for clamped width
- Sub-module bit_field_mask_gen: combinational (lsb, width) → (mask, clip). It is reused by the selection path for its extract mask.

Test Plan:
- Basic insert: base=0xFFFFFFFF, field=0xABCD, lsb=4, width=16 → out_word=0xFFFABCDF, out_clipped=0, out_valid at N+3.
- Clipping: base=0x00000000, field=0x1234, lsb=24, width=16 → out_word=0x34000000, out_clipped=1.
- No-op and clamp:
  - width=0, base=0x12345678 → out_word=0x12345678, clipped=0.
  - width=31, field=0xFFFF, lsb=0, base=0 → out_word=0x0000FFFF, clipped=0.
- Backpressure: out_ready low 3 cycles in HOLD → out_valid stays 1, out_word stable, in_ready 0. Accept on out_ready=1, then in_ready=1 next cycle.
- Reset mid-operation: reset asserted in MERGE → next cycle IDLE, in_ready=1, out_valid=0, out_word=0, and no result is emitted afterwards.
- Back-to-back: in_valid held high with 3 requests, out_ready=1 → results at cycles 3, 7, 11 with correct values in order.
